// File: rtl/p2p_upper_arbiter_if.sv
// Handshake bundle between the upstream p2p forward-up sources and the merged p2p_upper channel.
// Source beats are packed per source: slice i of s_head/s_data belongs to source i.
interface p2p_upper_arbiter_if #(
  parameter int NUM_SRC = 2,
  parameter int HEAD_W  = 64,
  parameter int DATA_W  = 256
);
  logic [NUM_SRC-1:0]        s_valid;
  logic [NUM_SRC-1:0]        s_last;
  logic [NUM_SRC*HEAD_W-1:0] s_head;
  logic [NUM_SRC*DATA_W-1:0] s_data;
  logic [NUM_SRC-1:0]        s_ready;
  logic                      m_valid;
  logic                      m_last;
  logic [HEAD_W-1:0]         m_head;
  logic [DATA_W-1:0]         m_data;
  logic                      m_ready;

  // master: the side that produces source beats and consumes the merged channel
  modport master (
    output s_valid, s_last, s_head, s_data, m_ready,
    input  s_ready, m_valid, m_last, m_head, m_data
  );

  // slave: the arbiter itself
  modport slave (
    input  s_valid, s_last, s_head, s_data, m_ready,
    output s_ready, m_valid, m_last, m_head, m_data
  );
endinterface

// File: rtl/p2p_upper_arbiter.sv
// Packet-granular round-robin merge of NUM_SRC p2p forward-up channels into one registered
// p2p_upper channel; the granted source owns the output until its last beat is accepted.
module p2p_upper_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int HEAD_W  = 64,
  parameter int DATA_W  = 256,
  parameter int IDX_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  p2p_upper_arbiter_if.slave   bus,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 busy
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_vld;
  logic [IDX_W-1:0]  rr_nxt;
  logic              sel_valid;
  logic              sel_last;
  logic [HEAD_W-1:0] sel_head;
  logic [DATA_W-1:0] sel_data;
  logic              out_rdy;
  logic              accept;

  // Walk downward so the closest source at or after rr_ptr is the one left standing.
  always_comb begin
    int j;
    pick_vld = 1'b0;
    pick_idx = '0;
    j        = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % NUM_SRC;
      if (bus.s_valid[j]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_head  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_valid = bus.s_valid[i];
        sel_last  = bus.s_last[i];
        sel_head  = bus.s_head[i*HEAD_W +: HEAD_W];
        sel_data  = bus.s_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output register is a one-deep skid: refill whenever it is empty or draining this cycle.
  assign out_rdy = ~bus.m_valid | bus.m_ready;
  assign accept  = (state == ST_GRANT) & sel_valid & out_rdy;
  assign rr_nxt  = (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
  assign busy    = (state == ST_GRANT);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_rdy
    assign bus.s_ready[i] = (state == ST_GRANT) & (grant_idx == IDX_W'(i)) & out_rdy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      bus.m_valid <= 1'b0;
      bus.m_last  <= 1'b0;
      bus.m_head  <= '0;
      bus.m_data  <= '0;
    end else begin
      if (state == ST_IDLE) begin
        if (pick_vld) begin
          grant_idx <= pick_idx;
          state     <= ST_GRANT;
        end
      end else if (accept && sel_last) begin
        rr_ptr <= rr_nxt;
        state  <= ST_IDLE;
      end

      if (accept) begin
        bus.m_valid <= 1'b1;
        bus.m_last  <= sel_last;
        bus.m_head  <= sel_head;
        bus.m_data  <= sel_data;
      end else if (bus.m_ready) begin
        bus.m_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_p2p_upper_arbiter.sv
// Bench for p2p_upper_arbiter: directed scenario table plus randomized packets, scored against
// a packet-level round-robin model.
module tb_p2p_upper_arbiter;
  localparam int NS = 4;
  localparam int HW = 16;
  localparam int DW = 32;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  p2p_upper_arbiter_if #(.NUM_SRC(NS), .HEAD_W(HW), .DATA_W(DW)) ifc();
  logic [IW-1:0] grant_idx;
  logic          busy;

  p2p_upper_arbiter #(.NUM_SRC(NS), .HEAD_W(HW), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifc),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [HW-1:0] head;
    logic          last;
  } beat_t;

  typedef struct {
    logic [NS-1:0]   mask;
    int              len;
    int              pkts;
    int              n;
    logic [7:0][2:0] ord;
  } vec_t;

  beat_t src_q[NS][$];
  beat_t exp_q[$];
  int    mdl_len[NS][$];
  int    mdl_id[NS][$];
  int    got_src[$];
  bit    mr_pat[$];

  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    last_cyc = -1;
  int    mdl_rr = 0;
  int    pkt_id = 0;
  int    hold_cnt = 0;
  int    hold_seen = 0;
  bit    bub_chk = 0;
  bit    gap_en = 0;
  bit    mr_rand = 0;
  bit    hold_arm = 0;
  bit    hold_now = 0;
  bit    stall_pend = 0;
  beat_t stall_val;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic beat_t mk_beat(input int s, input int id, input int b, input int len);
    beat_t r;
    r.data = {8'(s), 8'(id), 16'(b)};
    r.head = {8'(s), 8'(id)};
    r.last = (b == len - 1);
    return r;
  endfunction

  task automatic add_pkt(input int s, input int len);
    int id;
    id = pkt_id;
    pkt_id++;
    for (int b = 0; b < len; b++) src_q[s].push_back(mk_beat(s, id, b, len));
    mdl_len[s].push_back(len);
    mdl_id[s].push_back(id);
  endtask

  // Whole-packet round robin: serve the first source at/after the pointer that has a packet queued.
  task automatic model_run();
    bit found;
    do begin
      found = 0;
      for (int k = 0; k < NS && !found; k++) begin
        int s, len, id;
        s = (mdl_rr + k) % NS;
        if (mdl_len[s].size() > 0) begin
          len = mdl_len[s].pop_front();
          id  = mdl_id[s].pop_front();
          for (int b = 0; b < len; b++) exp_q.push_back(mk_beat(s, id, b, len));
          mdl_rr = (s + 1) % NS;
          found  = 1;
        end
      end
    end while (found);
  endtask

  function automatic bit pending();
    bit p;
    p = (exp_q.size() > 0) || (ifc.m_valid === 1'b1);
    for (int s = 0; s < NS; s++) if (src_q[s].size() > 0) p = 1;
    return p;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats still expected after %0d cycles", exp_q.size(), budget);
      for (int s = 0; s < NS; s++) src_q[s].delete();
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Drive on the falling edge, sample one time unit before the rising edge.
  always @(negedge clk) begin : bfm
    bit    drop, first;
    beat_t b, got;
    cyc++;
    if (mr_pat.size() > 0) ifc.m_ready = mr_pat.pop_front();
    else if (mr_rand)      ifc.m_ready = 1'($urandom_range(0, 1));
    else                   ifc.m_ready = 1'b1;
    hold_now = 0;
    for (int s = 0; s < NS; s++) begin
      ifc.s_valid[s] = 1'b0;
      ifc.s_last[s]  = 1'b0;
      if (src_q[s].size() > 0) begin
        b     = src_q[s][0];
        first = (b.data[15:0] == 16'd0);
        drop  = 0;
        if (s == 0 && hold_arm && !first) begin
          hold_cnt = 5;
          hold_arm = 0;
        end
        if (s == 0 && hold_cnt > 0) begin
          drop = 1;
          hold_cnt--;
          hold_now = 1;
        end
        if (gap_en && !first && $urandom_range(0, 3) == 0) drop = 1;
        if (!drop) begin
          ifc.s_valid[s]            = 1'b1;
          ifc.s_last[s]             = b.last;
          ifc.s_head[s*HW +: HW]    = b.head;
          ifc.s_data[s*DW +: DW]    = b.data;
        end
      end
    end
    #4;
    if (rst_n) begin
      for (int s = 0; s < NS; s++) begin
        if (ifc.s_valid[s] && ifc.s_ready[s]) begin
          chk("grant_on_accept", 64'(grant_idx), 64'(s));
          chk("busy_on_accept", 64'(busy), 64'd1);
          void'(src_q[s].pop_front());
        end
      end
      if (hold_now) begin
        hold_seen++;
        chk("hold_busy", 64'(busy), 64'd1);
        chk("hold_grant", 64'(grant_idx), 64'd0);
        chk("hold_ready1", 64'(ifc.s_ready[1]), 64'd0);
      end
      if (stall_pend) begin
        got = {ifc.m_data, ifc.m_head, ifc.m_last};
        chk("stall_valid", 64'(ifc.m_valid), 64'd1);
        chk("stall_hold", 64'(got), 64'(stall_val));
        stall_pend = 0;
      end
      if (ifc.m_valid && ifc.m_ready) begin
        got = {ifc.m_data, ifc.m_head, ifc.m_last};
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected no beat", got);
        end else begin
          chk("beat", 64'(got), 64'(exp_q.pop_front()));
        end
        if (got.data[15:0] == 16'd0) begin
          got_src.push_back(int'(got.data[31:24]));
          if (bub_chk && last_cyc >= 0) chk("bubble_gap", 64'(cyc - last_cyc), 64'd2);
        end
        if (got.last) last_cyc = cyc;
      end else if (ifc.m_valid) begin
        stall_pend = 1;
        stall_val  = {ifc.m_data, ifc.m_head, ifc.m_last};
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[4];

  initial begin
    vecs[0] = '{mask: 4'b0011, len: 3, pkts: 2, n: 4, ord: {12'd0, 3'd1, 3'd0, 3'd1, 3'd0}};
    vecs[1] = '{mask: 4'b0001, len: 4, pkts: 1, n: 1, ord: {21'd0, 3'd0}};
    vecs[2] = '{mask: 4'b0010, len: 1, pkts: 1, n: 1, ord: {21'd0, 3'd1}};
    vecs[3] = '{mask: 4'b1111, len: 1, pkts: 1, n: 4, ord: {12'd0, 3'd1, 3'd0, 3'd3, 3'd2}};

    // Power-on reset values
    #2;
    chk("rst_m_valid", 64'(ifc.m_valid), 64'd0);
    chk("rst_m_last", 64'(ifc.m_last), 64'd0);
    chk("rst_m_head", 64'(ifc.m_head), 64'd0);
    chk("rst_m_data", 64'(ifc.m_data), 64'd0);
    chk("rst_s_ready", 64'(ifc.s_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_idx), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a long packet
    add_pkt(2, 8);
    model_run();
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_m_valid", 64'(ifc.m_valid), 64'd0);
    chk("async_s_ready", 64'(ifc.s_ready), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    for (int s = 0; s < NS; s++) src_q[s].delete();
    exp_q.delete();
    got_src.delete();
    stall_pend = 0;
    mdl_rr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed scenarios: every listed source offers its packets at once
    bub_chk = 1;
    for (int v = 0; v < 4; v++) begin
      got_src.delete();
      last_cyc = -1;
      for (int p = 0; p < vecs[v].pkts; p++)
        for (int s = 0; s < NS; s++)
          if (vecs[v].mask[s]) add_pkt(s, vecs[v].len);
      model_run();
      drain(500);
      chk("order_count", 64'(got_src.size()), 64'(vecs[v].n));
      for (int k = 0; k < vecs[v].n && k < got_src.size(); k++)
        chk("grant_order", 64'(got_src[k]), 64'(vecs[v].ord[k]));
    end
    bub_chk = 0;

    // Backpressure during a source-1 packet
    got_src.delete();
    foreach (mr_pat[i]) mr_pat.delete(i);
    mr_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    add_pkt(1, 6);
    model_run();
    drain(500);
    chk("bp_pkt_count", 64'(got_src.size()), 64'd1);

    // Granted source 0 stalls mid-packet while source 1 waits
    got_src.delete();
    hold_seen = 0;
    hold_arm = 1;
    add_pkt(0, 4);
    add_pkt(1, 2);
    model_run();
    drain(500);
    chk("hold_cycles", 64'(hold_seen), 64'd5);
    chk("hold_order_count", 64'(got_src.size()), 64'd2);
    if (got_src.size() == 2) begin
      chk("hold_order0", 64'(got_src[0]), 64'd0);
      chk("hold_order1", 64'(got_src[1]), 64'd1);
    end

    // Randomized packets, valid gaps and output backpressure
    gap_en = 1;
    for (int r = 0; r < 30; r++) begin
      logic [NS-1:0] mask;
      mr_rand = r[0];
      mask = NS'($urandom_range(1, (1 << NS) - 1));
      got_src.delete();
      for (int s = 0; s < NS; s++)
        if (mask[s]) begin
          int np;
          np = $urandom_range(1, 3);
          for (int p = 0; p < np; p++) add_pkt(s, $urandom_range(1, 5));
        end
      model_run();
      drain(3000);
    end
    gap_en = 0;
    mr_rand = 0;
    chk("final_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
